// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One bit per cycle: shift-add multiply and restoring divide share a single
// 2*XLEN accumulator. Signed operations run on magnitudes and the sign is
// applied to the final result as it is registered.
//
// Handshake: start_i is a level held by ID/EX for the whole instruction.
// The unit asserts stall_o while it owns the pipeline; result_valid_o is a
// single-cycle strobe in DONE (stall_o low there so EX/MEM captures
// result_o/rd_o). start_i is ignored in DONE because the same instruction is
// still in ID/EX. flush_i kills everything and returns to IDLE.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [5:0]      ITERS    = 6'(XLEN);

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;

  // Input-side decode (only meaningful in IDLE with start_i)
  logic            signed_a, signed_b, is_div;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] iter_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   final_res;

  // Operand sign handling and special-case detection for the incoming op
  always_comb begin
    is_div   = op_i[2];
    signed_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    signed_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg    = signed_a & rs1_i[XLEN-1];
    b_neg    = signed_b & rs2_i[XLEN-1];
    a_mag    = a_neg ? (~rs1_i + 1'b1) : rs1_i;
    b_mag    = b_neg ? (~rs2_i + 1'b1) : rs2_i;
    div_zero = is_div && (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);
    special  = div_zero || div_ovf;
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) begin
      special_res = op_i[1] ? rs1_i : ALL_ONES;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : INT_MIN;
    end else begin
      special_res = '0;
    end
  end

  // One radix-2 step of either the multiplier or the divider, plus result fixup
  always_comb begin
    // Multiply: acc = {partial_hi, multiplier}; add multiplicand when lsb set, shift right
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder
    div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
    div_sub  = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
    div_next = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                      : {acc_q[2*XLEN-2:0], 1'b0};
    iter_next = op_q[2] ? div_next : mul_next;

    prod_signed = (a_neg_q ^ b_neg_q) ? (~iter_next + 1'b1) : iter_next;
    quot = iter_next[XLEN-1:0];
    rem  = iter_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                     final_res = prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                   final_res = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            final_res = (a_neg_q ^ b_neg_q) ? (~quot + 1'b1) : quot;
      OP_REM, OP_REMU:            final_res = a_neg_q ? (~rem + 1'b1) : rem;
      default:                    final_res = '0;
    endcase
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = special ? S_DONE : S_BUSY;
      S_BUSY: if (cnt_q == 6'd1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else if (!flush_i) begin
      if ((state_q == S_IDLE) && start_i) begin
        op_q    <= op_i;
        rd_o    <= rd_i;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        cnt_q   <= ITERS;
        if (is_div) begin
          acc_q  <= {{XLEN{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end else begin
          acc_q  <= {{XLEN{1'b0}}, b_mag};
          opnd_q <= a_mag;
        end
        if (special) result_o <= special_res;
      end else if (state_q == S_BUSY) begin
        acc_q <= iter_next;
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) result_o <= final_res;
      end
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign stall_o        = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_BUSY);
  assign result_valid_o = (state_q == S_DONE) & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: timing of stall/valid and RV32M results.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int vectors;
  int miscompares;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .start_i(start_i),
    .op_i(op_i),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .rd_i(rd_i),
    .stall_o(stall_o),
    .busy_o(busy_o),
    .result_valid_o(result_valid_o),
    .result_o(result_o),
    .rd_o(rd_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one instruction right after a rising edge and track it to DONE.
  // exp_lat is the cycle index (cycle k = 0) of the result_valid_o pulse,
  // which also equals the number of stall cycles.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int stalls;
    bit got;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = rd;
    stalls  = 0;
    got     = 1'b0;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      if (result_valid_o) begin
        got = 1'b1;
        vectors++;
        if (cyc !== exp_lat) begin
          miscompares++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        vectors++;
        if (result_o !== exp_res) begin
          miscompares++;
          $display("FAIL %s result: got %h want %h", name, result_o, exp_res);
        end
        vectors++;
        if (rd_o !== rd) begin
          miscompares++;
          $display("FAIL %s rd: got %0d want %0d", name, rd_o, rd);
        end
        vectors++;
        if (stall_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s stall_in_done: got %b want 0", name, stall_o);
        end
      end else if (stall_o) begin
        stalls++;
      end
      if (cyc == 1 && exp_lat > 1) begin
        vectors++;
        if (busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy: got %b want 1", name, busy_o);
        end
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: no result_valid_o within 60 cycles", name);
    end else if (stalls !== exp_lat) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_lat);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; start_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall_o, busy_o, result_valid_o, result_o, rd_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b busy=%b valid=%b res=%h rd=%0d want all 0",
               stall_o, busy_o, result_valid_o, result_o, rd_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 33);
  endtask

  // Each op starts in the IDLE cycle right after the previous DONE
  task automatic test_back_to_back();
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
    run_op("mulh",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33);
    run_op("mulhsu",3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_div();
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7",3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33);
    run_op("remu_100_7",3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33);
  endtask

  task automatic test_special();
    run_op("divu_by0", 3'd5, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'd7, 32'h0000_1234, 32'd0, 5'd11, 32'h0000_1234, 1);
    run_op("rem_by0",  3'd6, 32'hFFFF_FF00, 32'd0, 5'd12, 32'hFFFF_FF00, 1);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);
  endtask

  task automatic test_flush();
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd6; rd_i = 5'd20;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle_valid: got %b want 0", result_valid_o);
    end
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall_o, busy_o, result_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_after: got stall=%b busy=%b valid=%b want 000",
               stall_o, busy_o, result_valid_o);
    end
    @(posedge clk);
    #1;
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 33);
  endtask

  task automatic test_reset_mid();
    int seen;
    start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd22;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stall_o, busy_o, result_valid_o, result_o, rd_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got stall=%b busy=%b valid=%b res=%h rd=%0d want all 0",
               stall_o, busy_o, result_valid_o, result_o, rd_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o || busy_o) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_start();
    flush_i = 1'b1; start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd23;
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_stall: got %b want 0", stall_o);
    end
    @(posedge clk);
    #1 flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_o, result_valid_o, stall_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_start_idle: got busy=%b valid=%b stall=%b want 000",
               busy_o, result_valid_o, stall_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_flush_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (control, forwarded rs1/rs2 values, rd).
- Holds the pipeline through a global stall while it computes.
- Presents a one-cycle-valid result to the EX/MEM boundary.
- Radix-2 (one bit per cycle) shift-add multiply and restoring divide; one shared 64-bit datapath.

Parameters:
XLEN, 32, operand/result width; only 32 is supported. The iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush_i  input  1  kill in-flight operation (branch/exception flush)
start_i  input  1  ID/EX holds a valid M-extension instruction
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  input  XLEN  forwarded operand A (dividend/multiplicand)
rs2_i  input  XLEN  forwarded operand B (divisor/multiplier)
rd_i  input  5  destination register
stall_o  output  1  freeze PC, IF/ID and ID/EX (combinational)
busy_o  output  1  FSM not IDLE (registered state decode)
result_valid_o  output  1  result_o/rd_o valid this cycle
result_o  output  XLEN  computed result
rd_o  output  5  destination register of the result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Reset overrides all other inputs.
- Reset values: state IDLE; result_o, rd_o, internal accumulators and counter all 0. With state IDLE, stall_o=0 (given start_i=0), busy_o=0 and result_valid_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If start_i=1, latch op_i, rd_i, operand magnitudes and sign flags.
  - Special case (divide with rs2=0, or signed DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): load the final result and go to DONE.
  - Otherwise load counter=XLEN and go to BUSY.
- BUSY:
  - One iteration per cycle; counter decrements.
  - When counter reaches 1, the last iteration completes and the next state is DONE, with the final result registered into result_o.
- DONE:
  - result_valid_o=1 for exactly one cycle, then next state is IDLE.
  - start_i is ignored in DONE, because the same instruction is still held in ID/EX.
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. stall_o is 0 in DONE so that EX/MEM captures the result.
- Latency:
  - start_i sampled in IDLE at cycle k.
  - BUSY during cycles k+1..k+32; DONE at cycle k+33.
  - stall_o is high for 33 cycles (k..k+32).
  - Special cases: stall_o high only at cycle k; DONE at k+1.
- Arithmetic:
  - Signed operands are converted to magnitude. Sign flags: MULH both operands, MULHSU rs1 only, DIV/REM both.
  - The unsigned core runs on the magnitudes.
  - Product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits of the 64-bit product.
- Special results:
  - x/0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give x.
  - Signed overflow 0x80000000/-1: DIV gives 0x80000000; REM gives 0.
- flush_i:
  - In any state, next state is IDLE.
  - result_valid_o is forced to 0 in the flush cycle and the next.
  - No result is delivered for the killed operation.
  - start_i is ignored during the flush cycle.
- Reset mid-operation: on the next edge, identical to power-on reset. No result is produced.
- Simultaneous flush_i and start_i in IDLE: flush wins; the operation is not started and stall_o=0.
- Back-to-back M instructions: the second start_i is seen in IDLE the cycle after DONE. There is no dead cycle beyond DONE.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> stall_o high 33 cycles; result_valid_o pulse at k+33 with result_o=0xFFFFFFEB and rd_o=rd_i.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF*0x2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each takes 33 stall cycles.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0. Each has 1 stall cycle and result_valid at k+1.
- Flush in BUSY at iteration 10 -> IDLE next cycle; stall_o=0 and busy_o=0; no result_valid_o pulse. New MUL 3*4 started next cycle -> 12 after 33 cycles.
- rst_n low for one cycle mid-BUSY -> all outputs 0 the next cycle and state IDLE; flush_i and start_i together in IDLE -> no stall and no operation.
